// File: rtl/branch_seq_ctrl_if.sv
// Decode-stage branch bundle between the D stage / forwarding network and the
// branch sequencer: instruction fields and operands in, stall/redirect/BD tag and counters out.
interface branch_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             flush;
    logic             hold;
    logic             d_valid;
    logic             d_is_br;
    logic [5:0]       d_opcode;
    logic [4:0]       d_rt;
    logic [15:0]      d_imm;
    logic [31:0]      d_pc;
    logic [31:0]      rs_val;
    logic [31:0]      rt_val;
    logic             rs_ready;
    logic             rt_ready;
    logic             br_stall;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             d_bd;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output flush, hold, d_valid, d_is_br, d_opcode, d_rt, d_imm, d_pc,
               rs_val, rt_val, rs_ready, rt_ready,
        input  br_stall, br_taken, br_target, d_bd, br_cnt, taken_cnt, stall_cnt
    );

    modport slave (
        input  flush, hold, d_valid, d_is_br, d_opcode, d_rt, d_imm, d_pc,
               rs_val, rt_val, rs_ready, rt_ready,
        output br_stall, br_taken, br_target, d_bd, br_cnt, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/branch_seq_ctrl.sv
// ID-stage branch sequencer: stalls until operands are final, resolves condition
// and target, tags the delay slot (BD) and keeps saturating branch statistics.
module branch_seq_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    branch_seq_ctrl_if.slave   bus
);
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SLOT = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic br_req, need_rt, ready, br_stall, resolve, cond, br_taken, d_bd;
    logic signed [31:0] rs_s, rt_s;
    logic [31:0] offset;
    logic [31:0] br_target;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    always_comb begin
        br_req   = bus.d_valid & bus.d_is_br;
        need_rt  = (bus.d_opcode == OP_BEQ) | (bus.d_opcode == OP_BNE);
        ready    = bus.rs_ready & (bus.rt_ready | ~need_rt);
        br_stall = br_req & ~ready & ~bus.flush;
        resolve  = br_req & ready & ~bus.hold & ~bus.flush;
    end

    // Operands are compared as two's-complement values for the sign-based branches.
    always_comb begin
        rs_s = bus.rs_val;
        rt_s = bus.rt_val;
        cond = 1'b0;
        case (bus.d_opcode)
            OP_BEQ:    cond = (rs_s == rt_s);
            OP_BNE:    cond = (rs_s != rt_s);
            OP_BLEZ:   cond = (rs_s <= 0);
            OP_BGTZ:   cond = (rs_s > 0);
            OP_REGIMM: begin
                if (bus.d_rt == 5'b00000)
                    cond = (rs_s < 0);
                else if (bus.d_rt == 5'b00001)
                    cond = (rs_s >= 0);
            end
            default:   cond = 1'b0;
        endcase
    end

    always_comb begin
        offset    = {{14{bus.d_imm[15]}}, bus.d_imm, 2'b00};
        br_target = bus.d_pc + 32'd4 + offset;
        br_taken  = resolve & cond;
        d_bd      = (state_q == SLOT) & bus.d_valid & ~bus.flush;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (br_req && !ready)
                        state_d = WAIT;
                    else if (resolve)
                        state_d = SLOT;
                end
                WAIT: begin
                    if (resolve)
                        state_d = SLOT;
                    else if (!br_req)
                        state_d = IDLE;
                end
                // A branch sitting in the delay slot re-arms SLOT for its own slot.
                SLOT: begin
                    if (resolve)
                        state_d = SLOT;
                    else if (bus.d_valid && !bus.hold && !br_stall)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        br_cnt_d    = sat_inc(br_cnt_q, resolve);
        taken_cnt_d = sat_inc(taken_cnt_q, br_taken);
        stall_cnt_d = sat_inc(stall_cnt_q, br_stall);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.br_stall  = br_stall;
    assign bus.br_taken  = br_taken;
    assign bus.br_target = br_target;
    assign bus.d_bd      = d_bd;
    assign bus.br_cnt    = br_cnt_q;
    assign bus.taken_cnt = taken_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Scoreboard bench for branch_seq_ctrl: directed test-plan cases plus random
// traffic checked against a cycle-level behavioural model.
module tb_branch_seq_ctrl;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();
    branch_seq_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic        stall;
        logic        taken;
        logic [31:0] target;
        logic        bd;
        logic [31:0] brc;
        logic [31:0] tkc;
        logic [31:0] stc;
    } exp_t;

    typedef struct {
        logic rst, fl, hd, v, br;
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [31:0] pc, rsv, rtv;
        logic rsr, rtr;
    } stim_t;

    exp_t  sb[$];
    stim_t s;
    int checks = 0;
    int errors = 0;

    // Model: only "is the next D occupant a delay slot" matters for outputs.
    bit m_known = 0;
    bit m_slot  = 0;
    int m_br = 0, m_tk = 0, m_st = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t x;
        x = '{rst:0, fl:0, hd:0, v:0, br:0, op:0, rt:0, imm:0, pc:0, rsv:0, rtv:0, rsr:1, rtr:1};
        return x;
    endfunction

    function automatic stim_t br_stim(input logic [5:0] op, input logic [4:0] rt,
                                      input logic [15:0] imm, input logic [31:0] pc,
                                      input logic [31:0] rsv, input logic [31:0] rtv);
        stim_t x;
        x = idle_stim();
        x.v = 1; x.br = 1; x.op = op; x.rt = rt; x.imm = imm; x.pc = pc; x.rsv = rsv; x.rtv = rtv;
        return x;
    endfunction

    function automatic logic model_cond(input stim_t x);
        int signed a, b;
        a = x.rsv;
        b = x.rtv;
        case (x.op)
            6'd4: return a == b;
            6'd5: return a != b;
            6'd6: return a <= 0;
            6'd7: return a > 0;
            6'd1: begin
                if (x.rt == 5'd0) return a < 0;
                if (x.rt == 5'd1) return a >= 0;
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic int sat_add(input int v, input bit en);
        return (en && v < SAT) ? v + 1 : v;
    endfunction

    task automatic step();
        exp_t e;
        bit req, need, rdy, stall, res, tk;
        int signed off;
        @(posedge clk);
        #2;
        reset = s.rst; bus.flush = s.fl; bus.hold = s.hd; bus.d_valid = s.v; bus.d_is_br = s.br;
        bus.d_opcode = s.op; bus.d_rt = s.rt; bus.d_imm = s.imm; bus.d_pc = s.pc;
        bus.rs_val = s.rsv; bus.rt_val = s.rtv; bus.rs_ready = s.rsr; bus.rt_ready = s.rtr;
        req   = s.v && s.br;
        need  = (s.op == 6'd4) || (s.op == 6'd5);
        rdy   = s.rsr && (s.rtr || !need);
        stall = req && !rdy && !s.fl;
        res   = req && rdy && !s.hd && !s.fl;
        tk    = res && model_cond(s);
        off   = $signed(s.imm);
        off   = off * 4;
        e.stall  = stall;
        e.taken  = tk;
        e.target = s.pc + 32'd4 + off;
        e.bd     = m_slot && s.v && !s.fl;
        e.brc = m_br; e.tkc = m_tk; e.stc = m_st;
        if (m_known) sb.push_back(e);
        if (s.rst) begin
            m_known = 1; m_slot = 0; m_br = 0; m_tk = 0; m_st = 0;
        end else begin
            m_br = sat_add(m_br, res);
            m_tk = sat_add(m_tk, tk);
            m_st = sat_add(m_st, stall);
            if (s.fl)       m_slot = 0;
            else if (res)   m_slot = 1;
            else            m_slot = m_slot && !(s.v && !s.hd && !stall);
        end
        #2;
    endtask

    task automatic do_reset();
        s = idle_stim(); s.rst = 1;
        step(); step();
        s.rst = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_stall", bus.br_stall, e.stall);
            chk("sb_taken", bus.br_taken, e.taken);
            if (e.taken) chk("sb_target", bus.br_target, e.target);
            chk("sb_bd", bus.d_bd, e.bd);
            chk("sb_br_cnt", bus.br_cnt, e.brc);
            chk("sb_taken_cnt", bus.taken_cnt, e.tkc);
            chk("sb_stall_cnt", bus.stall_cnt, e.stc);
        end
    end

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0]  t3_op  [5] = '{6'd6, 6'd7, 6'd1, 6'd1, 6'd1};
        logic [4:0]  t3_rt  [5] = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd1};
        logic [31:0] t3_rs  [5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0};
        logic        t3_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        do_reset();
        chk("rst_bd", bus.d_bd, 0);
        chk("rst_br_cnt", bus.br_cnt, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);

        // BEQ taken, then its delay slot
        s = br_stim(6'd4, 5'd0, 16'h0004, 32'h0000_3000, 32'd5, 32'd5);
        step();
        chk("beq_taken", bus.br_taken, 1);
        chk("beq_target", bus.br_target, 32'h0000_3014);
        s = idle_stim(); s.v = 1;
        step();
        chk("beq_slot_bd", bus.d_bd, 1);
        chk("beq_br_cnt", bus.br_cnt, 1);
        chk("beq_taken_cnt", bus.taken_cnt, 1);

        // BNE waiting on rt
        do_reset();
        s = br_stim(6'd5, 5'd0, 16'h0010, 32'h0000_4000, 32'd1, 32'd2);
        s.rtr = 0;
        repeat (3) begin
            step();
            chk("bne_stall", bus.br_stall, 1);
        end
        s.rtr = 1;
        step();
        chk("bne_taken", bus.br_taken, 1);
        chk("bne_stall_off", bus.br_stall, 0);
        s = idle_stim();
        step();
        chk("bne_stall_cnt", bus.stall_cnt, 3);
        chk("bne_br_cnt", bus.br_cnt, 1);

        // Sign cases
        for (int i = 0; i < 5; i++) begin
            s = br_stim(t3_op[i], t3_rt[i], 16'h0004, 32'h0000_3000, t3_rs[i], 32'h0);
            step();
            chk($sformatf("sign_case%0d", i), bus.br_taken, t3_exp[i]);
            s = idle_stim();
            step();
        end
        s = br_stim(6'd4, 5'd0, 16'hFFFF, 32'h0000_3000, 32'd0, 32'd0);
        step();
        chk("neg_imm_target", bus.br_target, 32'h0000_3000);

        // Hold on the delay slot; hold on a WAITing branch
        do_reset();
        s = br_stim(6'd4, 5'd0, 16'h0008, 32'h0000_1000, 32'd7, 32'd7);
        step();
        s = idle_stim(); s.v = 1; s.hd = 1;
        step(); chk("hold_bd0", bus.d_bd, 1);
        step(); chk("hold_bd1", bus.d_bd, 1);
        s.hd = 0;
        step(); chk("hold_bd2", bus.d_bd, 1);
        step(); chk("hold_bd_after", bus.d_bd, 0);
        s = br_stim(6'd4, 5'd0, 16'h0008, 32'h0000_2000, 32'd3, 32'd3);
        s.rtr = 0;
        step();
        s.rtr = 1; s.hd = 1;
        repeat (3) begin
            step();
            chk("wait_hold_taken", bus.br_taken, 0);
            chk("wait_hold_stall", bus.br_stall, 0);
        end
        s = idle_stim();
        step();
        chk("wait_hold_br_cnt", bus.br_cnt, 1);

        // Flush in WAIT; reset mid-SLOT
        do_reset();
        s = br_stim(6'd5, 5'd0, 16'h0004, 32'h0000_5000, 32'd1, 32'd2);
        s.rtr = 0;
        step();
        s.fl = 1;
        step();
        chk("flush_stall", bus.br_stall, 0);
        chk("flush_taken", bus.br_taken, 0);
        s = idle_stim(); s.v = 1;
        step();
        chk("flush_bd", bus.d_bd, 0);
        chk("flush_stall_cnt", bus.stall_cnt, 1);
        chk("flush_br_cnt", bus.br_cnt, 0);
        s = br_stim(6'd4, 5'd0, 16'h0004, 32'h0000_5000, 32'd9, 32'd9);
        step();
        s = idle_stim(); s.v = 1; s.rst = 1;
        step();
        s.rst = 0;
        step();
        chk("rst_slot_bd", bus.d_bd, 0);
        chk("rst_slot_br_cnt", bus.br_cnt, 0);
        chk("rst_slot_taken_cnt", bus.taken_cnt, 0);
        chk("rst_slot_stall_cnt", bus.stall_cnt, 0);

        // Saturation of stall_cnt
        do_reset();
        s = br_stim(6'd6, 5'd0, 16'h0004, 32'h0000_6000, 32'd0, 32'd0);
        s.rsr = 0;
        repeat (17) step();
        s = idle_stim();
        step();
        chk("stall_cnt_sat", bus.stall_cnt, SAT);

        // Random traffic
        repeat (3000) begin
            s.rst = ($urandom_range(0, 99) < 2);
            s.fl  = ($urandom_range(0, 99) < 5);
            s.hd  = ($urandom_range(0, 99) < 15);
            s.v   = ($urandom_range(0, 99) < 80);
            s.br  = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 6))
                0: s.op = 6'd1;
                1: s.op = 6'd4;
                2: s.op = 6'd5;
                3: s.op = 6'd6;
                4: s.op = 6'd7;
                default: s.op = 6'($urandom_range(0, 63));
            endcase
            s.rt  = 5'($urandom_range(0, 3));
            s.imm = 16'($urandom);
            s.pc  = $urandom;
            s.rsv = rand_val();
            s.rtv = ($urandom_range(0, 3) == 0) ? s.rsv : rand_val();
            s.rsr = ($urandom_range(0, 99) < 75);
            s.rtr = ($urandom_range(0, 99) < 75);
            step();
        end

        s = idle_stim();
        step();
        step();
        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_seq_ctrl.md
Name: branch_seq_ctrl

Overview:
- ID-stage branch sequencer for the pipelined MIPS core.
- Waits for branch operands to become ready, stalling the front end meanwhile, then resolves the branch condition and target.
- Tracks the delay-slot instruction so it is tagged with the BD flag for CP0/EPC.
- Keeps saturating performance counters for resolved branches, taken branches and branch-stall cycles.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  exception/ERET flush of F/D. Synchronous; overrides all other inputs.
- hold  input  1  pipeline-wide freeze from other units (e.g. mult/div busy); D does not advance.
- d_valid  input  1  D stage holds a real instruction (not a bubble).
- d_is_br  input  1  the D instruction is a conditional branch.
- d_opcode  input  6  opcode field of the D instruction.
- d_rt  input  5  rt field of the D instruction (selects the REGIMM sub-op).
- d_imm  input  16  branch offset field.
- d_pc  input  32  PC of the D instruction.
- rs_val  input  32  forwarded rs value.
- rt_val  input  32  forwarded rt value.
- rs_ready  input  1  rs_val is final this cycle.
- rt_ready  input  1  rt_val is final this cycle.
- br_stall  output  1  freeze F/D and insert a bubble into E.
- br_taken  output  1  redirect the fetch PC to br_target this cycle.
- br_target  output  32  branch target address.
- d_bd  output  1  the D instruction is a delay slot.
- br_cnt  output  CNT_W  count of resolved branches.
- taken_cnt  output  CNT_W  count of taken branches.
- stall_cnt  output  CNT_W  count of cycles with br_stall asserted.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on port reset.
- Reset values: state=IDLE, all counters 0; br_stall=0, br_taken=0, d_bd=0; br_target holds no meaning while br_taken=0.
- Definitions:
  - br_req = d_valid & d_is_br.
  - need_rt = opcode is BEQ (000100) or BNE (000101).
  - ready = rs_ready & (rt_ready | ~need_rt).
- br_stall = br_req & ~ready & ~flush.
  - Asserted combinationally in the same cycle; no latency.
- resolve = br_req & ready & ~hold & ~flush.
- Branch conditions, with rs and rt compared as signed 32-bit values:
  - BEQ: rs==rt.
  - BNE: rs!=rt.
  - BLEZ (000110): rs<=0.
  - BGTZ (000111): rs>0.
  - REGIMM (000001) with rt=00000 (BLTZ): rs<0.
  - REGIMM (000001) with rt=00001 (BGEZ): rs>=0.
  - Any other opcode with d_is_br=1: not taken, but still counted as resolved.
- br_taken = resolve & cond.
  - Combinational, valid in the resolve cycle only.
- br_target = d_pc + 4 + {sext(d_imm), 2'b00}.
  - Computed modulo 2^32; wraps silently.
- FSM states:
  - IDLE: no branch outstanding.
  - WAIT: branch in D with operands not ready.
  - SLOT: branch resolved; the next instruction to occupy D is the delay slot.
- Transitions, evaluated at each clk edge in this priority order:
  1. reset or flush -> IDLE.
  2. IDLE: br_req & ~ready -> WAIT; resolve -> SLOT; otherwise stay in IDLE.
  3. WAIT: resolve -> SLOT; br_req dropped (bubble) -> IDLE; otherwise stay in WAIT.
  4. SLOT: d_valid & ~hold & ~br_stall (delay slot leaves D) -> IDLE. If the delay slot is itself a branch, resolve -> SLOT. While hold or ~d_valid, stay in SLOT.
- hold during WAIT: stay in WAIT, br_stall follows ready, no resolve.
- d_bd = (state==SLOT) & d_valid & ~flush.
  - Remains 1 across stall/hold cycles of the delay slot.
- Counters (registered, visible the cycle after the event):
  - br_cnt += resolve.
  - taken_cnt += br_taken.
  - stall_cnt += br_stall.
  - Each counter saturates at 2^CNT_W-1.
  - flush does not clear counters; only reset clears them.
- Flush mid-WAIT or mid-SLOT: the same cycle forces br_stall=0, br_taken=0, d_bd=0; next state is IDLE; no counter increments from the flushed instruction.

Test Plan:
- BEQ, rs=rt=5, both ready, d_pc=0x00003000, d_imm=0x0004 -> same cycle br_taken=1, br_target=0x00003014; next cycle d_bd=1 for the slot; br_cnt=1, taken_cnt=1.
- BNE, rt_ready low for 3 cycles, then rs=1, rt=2 ready -> br_stall=1 for 3 cycles, then br_taken=1; stall_cnt=3, br_cnt=1.
- Sign cases with rs=0x80000000 (negative):
  - BLEZ -> taken.
  - BGTZ -> not taken.
  - BLTZ -> taken.
  - BGEZ -> not taken.
  - BGEZ with rs=0 -> taken.
  - d_imm=0xFFFF at d_pc=0x00003000 -> br_target=0x00003000.
- Resolve, then hold=1 for 2 cycles with the delay slot in D -> d_bd stays 1 for 3 cycles, then 0 once the slot advances; a branch in the WAIT state under hold never resolves.
- flush asserted in the WAIT cycle -> br_stall=0 that cycle, state IDLE next cycle, counters unchanged; reset mid-SLOT -> d_bd=0 and all counters 0.
- CNT_W=4, 17 stall cycles -> stall_cnt saturates at 15.
